// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, FSM state type and index-width helper for the nibble serial adder
package adder_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/four_bit_adder.sv
// four_bit_adder: combinational 4-bit ripple stage with carry in and carry out
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide adder that reuses one 4-bit stage over NUM_NIBBLES clocks, LSB nibble first
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int  NUM_NIBBLES = 4,
    localparam int WIDTH       = NIBBLE_W * NUM_NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int            IW   = idx_width(NUM_NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NUM_NIBBLES - 1);

    state_t                               state_q, state_d;
    logic [NUM_NIBBLES-1:0][NIBBLE_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW-1:0]                        idx_q, idx_d;
    logic                                 carry_q, carry_d, cout_q, cout_d;
    logic [NIBBLE_W-1:0]                  st_sum;
    logic                                 st_cout;

    four_bit_adder u_stage (
        .a   (a_q[idx_q]),
        .b   (b_q[idx_q]),
        .cin (carry_q),
        .sum (st_sum),
        .cout(st_cout)
    );

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == ADD);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    // next state: latch operands on accept, process one slice per ADD cycle, hold result until taken
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            state_d = ADD;
        end else if (state_q == ADD) begin
            sum_d[idx_q] = st_sum;
            carry_d      = st_cout;
            idx_d        = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
            if (idx_q == LAST) begin
                cout_d  = st_cout;
                state_d = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers, cleared immediately by reset so no partial result survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and randomized checks of the serial adder against arithmetic a+b+cin
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;
    logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
    logic [3:0]  a1, b1, sum1;

    int checks = 0;
    int failures = 0;

    nibble_serial_adder #(.NUM_NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder #(.NUM_NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .busy(busy1)
    );

    // drives one operation on the 4-nibble DUT with out_ready high; starts and ends just after a negedge
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          output logic [15:0] s, output logic c, output int lat);
        lat = -1;
        s = 'x;
        c = 1'bx;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        cin = ic;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                lat = i;
                s = sum;
                c = cout;
                break;
            end
            @(negedge clk);
        end
        if (lat >= 0) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (sum !== 16'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat = -1;
        int low = 0;
        logic [15:0] s = 'x;
        logic c = 1'bx;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int i = 0; i < 20; i++) begin
            if (out_valid && lat < 0) begin lat = i; s = sum; c = cout; end
            if (in_ready) break;
            low++;
            @(negedge clk);
        end
        checks += 4;
        if (lat != 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        if (low != 5) begin failures++; $display("FAIL basic_in_ready_low got=%0d exp=5", low); end
        if (s !== 16'h5556) begin failures++; $display("FAIL basic_sum got=%h exp=5556", s); end
        if (c !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", c); end
    endtask

    task automatic test_carry();
        logic [15:0] s;
        logic c;
        int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, s, c, lat);
        checks += 3;
        if (lat != 4) begin failures++; $display("FAIL carry1_latency got=%0d exp=4", lat); end
        if (s !== 16'h0000) begin failures++; $display("FAIL carry1_sum got=%h exp=0000", s); end
        if (c !== 1'b1) begin failures++; $display("FAIL carry1_cout got=%b exp=1", c); end
        run_op(16'hFFFF, 16'hFFFF, 1'b1, s, c, lat);
        checks += 3;
        if (lat != 4) begin failures++; $display("FAIL carry2_latency got=%0d exp=4", lat); end
        if (s !== 16'hFFFF) begin failures++; $display("FAIL carry2_sum got=%h exp=ffff", s); end
        if (c !== 1'b1) begin failures++; $display("FAIL carry2_cout got=%b exp=1", c); end
    endtask

    task automatic test_backpressure();
        int seen = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'h00FF; b = 16'h0F01; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", out_valid); end
        in_valid = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks += 4;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", k, out_valid); end
            if (sum !== 16'h1000) begin failures++; $display("FAIL bp_hold_sum cyc=%0d got=%h exp=1000", k, sum); end
            if (cout !== 1'b0) begin failures++; $display("FAIL bp_hold_cout cyc=%0d got=%b exp=0", k, cout); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_ready got=%b exp=1", in_ready); end
        if (busy !== 1'b0) begin failures++; $display("FAIL bp_not_yet_accepted got=%b exp=0", busy); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL bp_accept_after got=%b exp=1", busy); end
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        seen = int'(out_valid);
        checks++;
        if (seen != 1 || sum !== 16'h2222) begin failures++; $display("FAIL bp_second_sum valid=%0d got=%h exp=2222", seen, sum); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [15:0] s;
        logic c;
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h00FF; b = 16'h0009; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        if (sum !== 16'h0) begin failures++; $display("FAIL rstmid_sum got=%h exp=0000", sum); end
        if (cout !== 1'b0) begin failures++; $display("FAIL rstmid_cout got=%b exp=0", cout); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(16'h0003, 16'h0004, 1'b0, s, c, lat);
        checks += 2;
        if (s !== 16'h0007) begin failures++; $display("FAIL rstmid_after_sum got=%h exp=0007", s); end
        if (c !== 1'b0) begin failures++; $display("FAIL rstmid_after_cout got=%b exp=0", c); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_q[$];
        logic [16:0] e;
        logic [15:0] ra, rb;
        logic rc;
        int k = 0;
        int got = 0;
        int prev = 0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({cout, sum} !== e) begin failures++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", got, {cout, sum}, e); end
                if (got > 0) begin
                    checks++;
                    if (cyc - prev != 6) begin failures++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=6", got, cyc - prev); end
                end
                prev = cyc;
                got++;
            end
            if (got == 3) break;
            if (in_ready) begin
                if (k < 3) begin
                    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
                    a = ra; b = rb; cin = rc; in_valid = 1'b1;
                    exp_q.push_back({1'b0, ra} + {1'b0, rb} + 17'(rc));
                    k++;
                end else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (got != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got); end
        @(negedge clk);
    endtask

    // sel=1 exercises the single-nibble instance, sel=0 the four-nibble one
    task automatic test_random(input logic sel, input int ops);
        logic [16:0] exp_q[$];
        logic [16:0] res, prev_res, e;
        logic [15:0] ra, rb;
        logic rc, rv, rr, ov, ir;
        logic prev_stall = 1'b0;
        int sent = 0;
        int done = 0;
        prev_res = '0;
        for (int cyc = 0; cyc < ops * 20 && done < ops; cyc++) begin
            ov = sel ? out_valid1 : out_valid;
            ir = sel ? in_ready1 : in_ready;
            res = sel ? {12'b0, cout1, sum1} : {cout, sum};
            if (prev_stall) begin
                checks++;
                if (!ov || res !== prev_res) begin failures++; $display("FAIL rand_hold n1=%b valid=%b got=%h exp=%h", sel, ov, res, prev_res); end
            end
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            rv = (sent < ops) && ($urandom_range(0, 9) < 8);
            rr = ($urandom_range(0, 9) < 7);
            if (sel) begin
                in_valid1 = rv; a1 = ra[3:0]; b1 = rb[3:0]; cin1 = rc; out_ready1 = rr;
            end else begin
                in_valid = rv; a = ra; b = rb; cin = rc; out_ready = rr;
            end
            if (rv && ir) begin
                exp_q.push_back(sel ? 17'({1'b0, ra[3:0]} + {1'b0, rb[3:0]} + 5'(rc))
                                    : {1'b0, ra} + {1'b0, rb} + 17'(rc));
                sent++;
            end
            if (ov && rr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_spurious n1=%b got=%h", sel, res);
                end else begin
                    e = exp_q.pop_front();
                    if (res !== e) begin failures++; $display("FAIL rand_result n1=%b idx=%0d got=%h exp=%h", sel, done, res, e); end
                end
                done++;
            end
            prev_stall = ov && !rr;
            prev_res = res;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b1;
        checks++;
        if (done != ops) begin failures++; $display("FAIL rand_count n1=%b got=%0d exp=%0d", sel, done, ops); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random(1'b0, 1000);
        test_random(1'b1, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
